inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Turns decoded commands (DecodedInst, proctypes) into 32-bit instruction words and writes them
//  sequentially into instruction memory, from word 0 upward. Exact inverse of the instruction
//  decoder: a decoded field set re-decodes to the same iType and fields. Sits between the host
//  command path (UART/scene loader) and the instruction BRAM the decoder reads.
// PARAMETERS
//  DEPTH  1024            instruction memory size in words; must be >= 2
//  AW     $clog2(DEPTH)   localparam, wr_addr width
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  cmd_in     in   DecodedInst  command fields (iType, data, data2, prop, prop2, lIndex, sIndex, sType)
//  cmd_valid  in   1      cmd_in valid
//  cmd_ready  out  1      encoder accepts cmd_in this cycle (transfer = valid & ready)
//  clear      in   1      rewind write pointer to 0 (start new program)
//  wr_en      out  1      instruction-memory write strobe
//  wr_addr    out  AW     write address
//  wr_data    out  32     instruction word
//  prog_len   out  AW+1   number of words written since reset/clear
//  full       out  1      prog_len == DEPTH
//  err        out  1      1-cycle pulse: unencodable command accepted and dropped
// BEHAVIOUR
//  Reset: state IDLE; wr_en=0, wr_addr=0, wr_data=0, prog_len=0, full=0, err=0.
//  Encoding (unused bits 0; opcodes from proctypes OpCode):
//   opRender    {29'b0, ocFType}, bits[10:9]=2'b00
//   opFrame     as opRender, bits[10:9]=2'b01
//   opCameraSet [31:16]=data [15:11]=prop [2:0]=ocCType
//   opLightSet  [31:16]=data [15:11]=prop [8:3]=lIndex [2:0]=ocLType
//   opShapeInit [31:16]=sIndex[18:3] [15:11]=sType [5:3]=sIndex[2:0] [2:0]=ocSIType
//   opShapeSet  word0: [31:16]=sIndex[18:3] [15:11]=prop [10:6]=prop2 [5:3]=sIndex[2:0] [2:0]=ocSEType
//               word1: [31:16]=data [15:0]=data2 (shape-data word, always directly after word0)
//   opShapeData / opUnsupported: accepted, nothing written, err=1 next cycle.
//  FSM: IDLE, SECOND.
//   IDLE: cmd_ready = !clear && free >= need; free = DEPTH-prog_len; need = 2 for opShapeSet else 1.
//     ready may depend on cmd_in.iType; cmd_valid must not depend on cmd_ready.
//     Transfer in cycle N: registered write in N+1 (wr_en=1, wr_addr=prog_len, wr_data=word0),
//     prog_len increments at the same edge. opShapeSet -> SECOND; else stay IDLE.
//   SECOND: cmd_ready=0; word1 written at prog_len in N+2; prog_len increments; -> IDLE.
//   Single-word commands back-to-back: one write per cycle, no bubbles.
//   opShapeSet: 2 cycles per command; never split across a full boundary (needs 2 free slots).
//  wr_en/err are single-cycle; wr_data/wr_addr hold their last value while wr_en=0.
//  full: combinational from prog_len; when full, cmd_ready=0; commands wait, never lost.
//  clear: highest priority after rst; next edge prog_len=0, state IDLE; pending word1 is
//   discarded (no write); cmd_ready=0 during clear, so no transfer coincides with it.
//  rst mid-SECOND: word1 discarded, all outputs to reset values.
// TESTING
//  1 CameraSet prop=3 data=16'hABCD -> 1 cycle later wr_en, addr 0, data {16'hABCD,5'd3,8'h00,ocCType}; prog_len=1
//  2 LightSet lIndex=9 prop=1 data=16'h0100, then Frame back-to-back -> writes at addr 0,1 on
//    consecutive cycles; word1 = {29'b0,ocFType} with [10:9]=01
//  3 ShapeSet sIndex=19'h12345 prop=2 prop2=7 data=16'h1111 data2=16'h2222 -> addr0
//    {16'h2468,5'd2,5'd7,3'd5,ocSEType}, addr1 32'h11112222, cmd_ready low for 1 cycle between
//  4 DEPTH=4: 3 singles then ShapeSet -> ready stays 0 for ShapeSet (free=1); single Render
//    accepted -> full=1, ready=0; clear -> prog_len=0, ShapeSet then accepted
//  5 opUnsupported -> no wr_en, err pulse 1 cycle, prog_len unchanged; clear asserted
//    in SECOND -> no word1 write, next command lands at addr 0
//  6 Round trip: random legal commands -> memory -> decoder; decoder dInst fields equal
//    originals (ShapeSet as two decodes: opShapeSet then opShapeData)

Source files
------------

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_encoder (with proctypes package)
//  Purpose  : Packs decoded commands into 32-bit instruction words and writes
//             them in order into instruction memory, starting at word 0.
//             The packing is the exact inverse of the instruction decoder.
//  Revision : 1.0  initial release
// ============================================================================

package proctypes;

    // Decoded instruction categories
    typedef enum logic [2:0] {
        opRender      = 3'd0,
        opFrame       = 3'd1,
        opCameraSet   = 3'd2,
        opLightSet    = 3'd3,
        opShapeInit   = 3'd4,
        opShapeSet    = 3'd5,
        opShapeData   = 3'd6,
        opUnsupported = 3'd7
    } IType;

    // Opcode field, instruction bits [2:0]
    typedef logic [2:0] OpCode;
    localparam OpCode ocFType  = 3'b001;
    localparam OpCode ocCType  = 3'b010;
    localparam OpCode ocLType  = 3'b011;
    localparam OpCode ocSIType = 3'b100;
    localparam OpCode ocSEType = 3'b101;

    typedef struct packed {
        IType        iType;
        logic [15:0] data;
        logic [15:0] data2;
        logic [4:0]  prop;
        logic [4:0]  prop2;
        logic [5:0]  lIndex;
        logic [18:0] sIndex;
        logic [4:0]  sType;
    } DecodedInst;

endpackage

module inst_encoder
    import proctypes::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  DecodedInst    cmd_in,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          clear,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [AW:0]   prog_len,
    output logic          full,
    output logic          err
);

    localparam logic [0:0]  c_IDLE   = 1'b0;
    localparam logic [0:0]  c_SECOND = 1'b1;
    localparam logic [AW:0] c_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_ONE    = (AW+1)'(1);
    localparam logic [AW:0] c_TWO    = (AW+1)'(2);

    logic [0:0]  r_state;
    logic [AW:0] r_prog_len;
    logic [31:0] r_word1;
    logic        r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_err;

    logic [AW:0] w_free;
    logic [AW:0] w_need;
    logic        w_xfer;
    logic        w_legal;
    logic [31:0] w_word0;
    logic [31:0] w_word1;

    // A two-word ShapeSet is only accepted when both words fit, so it is never split
    assign w_free    = c_DEPTH - r_prog_len;
    assign w_need    = (cmd_in.iType == opShapeSet) ? c_TWO : c_ONE;
    assign cmd_ready = (r_state == c_IDLE) && !clear && (w_free >= w_need);
    assign w_xfer    = cmd_valid && cmd_ready;
    assign w_word1   = {cmd_in.data, cmd_in.data2};

    // Pack the first (or only) instruction word; unused bits stay zero
    always_comb begin
        w_word0 = 32'h0;
        w_legal = 1'b1;
        case (cmd_in.iType)
            opRender:    w_word0 = {21'b0, 2'b00, 6'b0, ocFType};
            opFrame:     w_word0 = {21'b0, 2'b01, 6'b0, ocFType};
            opCameraSet: w_word0 = {cmd_in.data, cmd_in.prop, 8'b0, ocCType};
            opLightSet:  w_word0 = {cmd_in.data, cmd_in.prop, 2'b0,
                                    cmd_in.lIndex, ocLType};
            opShapeInit: w_word0 = {cmd_in.sIndex[18:3], cmd_in.sType, 5'b0,
                                    cmd_in.sIndex[2:0], ocSIType};
            opShapeSet:  w_word0 = {cmd_in.sIndex[18:3], cmd_in.prop, cmd_in.prop2,
                                    cmd_in.sIndex[2:0], ocSEType};
            default:     w_legal = 1'b0;
        endcase
    end

    // Write sequencer: one word per accepted command, ShapeSet adds a second word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_prog_len <= '0;
            r_word1    <= 32'h0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 32'h0;
            r_err      <= 1'b0;
        end else if (clear) begin
            // Rewind; any pending second word is dropped
            r_state    <= c_IDLE;
            r_prog_len <= '0;
            r_wr_en    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_xfer) begin
                        if (w_legal) begin
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= r_prog_len[AW-1:0];
                            r_wr_data  <= w_word0;
                            r_prog_len <= r_prog_len + c_ONE;
                            if (cmd_in.iType == opShapeSet) begin
                                r_word1 <= w_word1;
                                r_state <= c_SECOND;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_SECOND: begin
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= r_prog_len[AW-1:0];
                    r_wr_data  <= r_word1;
                    r_prog_len <= r_prog_len + c_ONE;
                    r_state    <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign prog_len = r_prog_len;
    assign full     = (r_prog_len == c_DEPTH);
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_encoder
//  Purpose  : Directed self-checking bench for inst_encoder (DEPTH 1024 and 4)
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_encoder;
    import proctypes::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Large instance
    DecodedInst  cmd_a = '0;
    logic        valid_a = 1'b0, clear_a = 1'b0;
    logic        ready_a, wr_en_a, full_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] data_a;
    logic [10:0] len_a;

    // Tiny instance for capacity behaviour
    DecodedInst  cmd_b = '0;
    logic        valid_b = 1'b0, clear_b = 1'b0;
    logic        ready_b, wr_en_b, full_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;
    logic [2:0]  len_b;

    int n_checks = 0;
    int n_pass   = 0;

    inst_encoder #(.DEPTH(1024)) u_dut_a (
        .clk(clk), .rst(rst), .cmd_in(cmd_a), .cmd_valid(valid_a), .cmd_ready(ready_a),
        .clear(clear_a), .wr_en(wr_en_a), .wr_addr(addr_a), .wr_data(data_a),
        .prog_len(len_a), .full(full_a), .err(err_a)
    );

    inst_encoder #(.DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .cmd_in(cmd_b), .cmd_valid(valid_b), .cmd_ready(ready_b),
        .clear(clear_b), .wr_en(wr_en_b), .wr_addr(addr_b), .wr_data(data_b),
        .prog_len(len_b), .full(full_b), .err(err_b)
    );

    // Memory image of everything instance A writes
    logic [31:0] mem [0:1023];
    int n_wr = 0;
    always @(negedge clk) begin
        if (wr_en_a) begin
            mem[addr_a] = data_a;
            n_wr = n_wr + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic DecodedInst mk(IType t, logic [15:0] d, logic [15:0] d2,
                                      logic [4:0] p, logic [4:0] p2, logic [5:0] li,
                                      logic [18:0] si, logic [4:0] st);
        DecodedInst c;
        c.iType = t; c.data = d; c.data2 = d2; c.prop = p; c.prop2 = p2;
        c.lIndex = li; c.sIndex = si; c.sType = st;
        return c;
    endfunction

    // Reference decoder: word -> fields
    function automatic DecodedInst dec(logic [31:0] w, bit shape_data);
        DecodedInst r;
        r = '0;
        if (shape_data) begin
            r.iType = opShapeData; r.data = w[31:16]; r.data2 = w[15:0];
        end else begin
            case (w[2:0])
                ocFType:  r.iType = (w[10:9] == 2'b01) ? opFrame : opRender;
                ocCType:  begin r.iType = opCameraSet; r.data = w[31:16]; r.prop = w[15:11]; end
                ocLType:  begin r.iType = opLightSet; r.data = w[31:16]; r.prop = w[15:11];
                                r.lIndex = w[8:3]; end
                ocSIType: begin r.iType = opShapeInit; r.sIndex = {w[31:16], w[5:3]};
                                r.sType = w[15:11]; end
                ocSEType: begin r.iType = opShapeSet; r.sIndex = {w[31:16], w[5:3]};
                                r.prop = w[15:11]; r.prop2 = w[10:6]; end
                default:  r.iType = opUnsupported;
            endcase
        end
        return r;
    endfunction

    // Fields of a command that its first word carries
    function automatic DecodedInst proj(DecodedInst c);
        DecodedInst r;
        r = '0;
        r.iType = c.iType;
        case (c.iType)
            opCameraSet: begin r.data = c.data; r.prop = c.prop; end
            opLightSet:  begin r.data = c.data; r.prop = c.prop; r.lIndex = c.lIndex; end
            opShapeInit: begin r.sIndex = c.sIndex; r.sType = c.sType; end
            opShapeSet:  begin r.sIndex = c.sIndex; r.prop = c.prop; r.prop2 = c.prop2; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (wr_en_a !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", wr_en_a); else n_pass++;
        n_checks++; if (addr_a !== 10'd0) $display("FAIL rst_addr: got %0d want 0", addr_a); else n_pass++;
        n_checks++; if (data_a !== 32'h0) $display("FAIL rst_data: got %h want 0", data_a); else n_pass++;
        n_checks++; if (len_a !== 11'd0) $display("FAIL rst_len: got %0d want 0", len_a); else n_pass++;
        n_checks++; if (full_a !== 1'b0 || err_a !== 1'b0) $display("FAIL rst_full_err: got %b%b want 00", full_a, err_a); else n_pass++;
        n_checks++; if (len_b !== 3'd0 || full_b !== 1'b0) $display("FAIL rst_b: got len %0d full %b want 0 0", len_b, full_b); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_a); else n_pass++;
    endtask

    task automatic test_camera();
        cmd_a = mk(opCameraSet, 16'hABCD, 16'h0, 5'd3, 5'd0, 6'd0, 19'd0, 5'd0);
        valid_a = 1'b1;
        #1;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL cam_ready: got %b want 1", ready_a); else n_pass++;
        step();
        valid_a = 1'b0;
        n_checks++; if (wr_en_a !== 1'b1) $display("FAIL cam_wr_en: got %b want 1", wr_en_a); else n_pass++;
        n_checks++; if (addr_a !== 10'd0) $display("FAIL cam_addr: got %0d want 0", addr_a); else n_pass++;
        n_checks++; if (data_a !== 32'hABCD1802) $display("FAIL cam_data: got %h want abcd1802", data_a); else n_pass++;
        n_checks++; if (len_a !== 11'd1) $display("FAIL cam_len: got %0d want 1", len_a); else n_pass++;
        step();
        n_checks++; if (wr_en_a !== 1'b0) $display("FAIL cam_wr_en_pulse: got %b want 0", wr_en_a); else n_pass++;
        n_checks++; if (data_a !== 32'hABCD1802) $display("FAIL cam_data_hold: got %h want abcd1802", data_a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        n_checks++; if (len_a !== 11'd0) $display("FAIL b2b_clear_len: got %0d want 0", len_a); else n_pass++;
        cmd_a = mk(opLightSet, 16'h0100, 16'h0, 5'd1, 5'd0, 6'd9, 19'd0, 5'd0);
        valid_a = 1'b1;
        #1;
        step();
        cmd_a = mk(opFrame, 16'h0, 16'h0, 5'd0, 5'd0, 6'd0, 19'd0, 5'd0);
        #1;
        n_checks++; if (wr_en_a !== 1'b1 || addr_a !== 10'd0 || data_a !== 32'h0100084B)
            $display("FAIL b2b_light: got en %b addr %0d data %h want 1 0 0100084b", wr_en_a, addr_a, data_a); else n_pass++;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL b2b_ready: got %b want 1", ready_a); else n_pass++;
        step();
        valid_a = 1'b0;
        n_checks++; if (wr_en_a !== 1'b1 || addr_a !== 10'd1 || data_a !== 32'h00000201)
            $display("FAIL b2b_frame: got en %b addr %0d data %h want 1 1 00000201", wr_en_a, addr_a, data_a); else n_pass++;
        n_checks++; if (len_a !== 11'd2) $display("FAIL b2b_len: got %0d want 2", len_a); else n_pass++;
        step();
    endtask

    task automatic test_shapeset();
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        cmd_a = mk(opShapeSet, 16'h1111, 16'h2222, 5'd2, 5'd7, 6'd0, 19'h12345, 5'd0);
        valid_a = 1'b1;
        #1;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL ss_ready: got %b want 1", ready_a); else n_pass++;
        step();
        cmd_a = mk(opRender, 16'h0, 16'h0, 5'd0, 5'd0, 6'd0, 19'd0, 5'd0);
        #1;
        n_checks++; if (ready_a !== 1'b0) $display("FAIL ss_ready_second: got %b want 0", ready_a); else n_pass++;
        n_checks++; if (wr_en_a !== 1'b1 || addr_a !== 10'd0 || data_a !== 32'h246811ED)
            $display("FAIL ss_word0: got en %b addr %0d data %h want 1 0 246811ed", wr_en_a, addr_a, data_a); else n_pass++;
        step();
        n_checks++; if (wr_en_a !== 1'b1 || addr_a !== 10'd1 || data_a !== 32'h11112222)
            $display("FAIL ss_word1: got en %b addr %0d data %h want 1 1 11112222", wr_en_a, addr_a, data_a); else n_pass++;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL ss_ready_back: got %b want 1", ready_a); else n_pass++;
        step();
        valid_a = 1'b0;
        n_checks++; if (wr_en_a !== 1'b1 || addr_a !== 10'd2 || data_a !== 32'h00000001 || len_a !== 11'd3)
            $display("FAIL ss_waiting_cmd: got en %b addr %0d data %h len %0d want 1 2 00000001 3",
                     wr_en_a, addr_a, data_a, len_a); else n_pass++;
        step();
    endtask

    task automatic test_full();
        clear_b = 1'b1;
        step();
        clear_b = 1'b0;
        cmd_b = mk(opCameraSet, 16'h0042, 16'h0, 5'd1, 5'd0, 6'd0, 19'd0, 5'd0);
        valid_b = 1'b1;
        #1;
        step(); step(); step();
        cmd_b = mk(opShapeSet, 16'h1111, 16'h2222, 5'd2, 5'd7, 6'd0, 19'h12345, 5'd0);
        #1;
        n_checks++; if (len_b !== 3'd3) $display("FAIL full_len3: got %0d want 3", len_b); else n_pass++;
        n_checks++; if (ready_b !== 1'b0) $display("FAIL full_ss_blocked: got %b want 0", ready_b); else n_pass++;
        step(); step();
        n_checks++; if (wr_en_b !== 1'b0 || len_b !== 3'd3)
            $display("FAIL full_ss_wait: got en %b len %0d want 0 3", wr_en_b, len_b); else n_pass++;
        cmd_b = mk(opRender, 16'h0, 16'h0, 5'd0, 5'd0, 6'd0, 19'd0, 5'd0);
        #1;
        n_checks++; if (ready_b !== 1'b1) $display("FAIL full_single_ready: got %b want 1", ready_b); else n_pass++;
        step();
        n_checks++; if (wr_en_b !== 1'b1 || addr_b !== 2'd3 || full_b !== 1'b1 || len_b !== 3'd4)
            $display("FAIL full_last: got en %b addr %0d full %b len %0d want 1 3 1 4",
                     wr_en_b, addr_b, full_b, len_b); else n_pass++;
        n_checks++; if (ready_b !== 1'b0) $display("FAIL full_ready: got %b want 0", ready_b); else n_pass++;
        step();
        n_checks++; if (wr_en_b !== 1'b0 || len_b !== 3'd4)
            $display("FAIL full_hold: got en %b len %0d want 0 4", wr_en_b, len_b); else n_pass++;
        clear_b = 1'b1;
        cmd_b = mk(opShapeSet, 16'h1111, 16'h2222, 5'd2, 5'd7, 6'd0, 19'h12345, 5'd0);
        #1;
        n_checks++; if (ready_b !== 1'b0) $display("FAIL full_clear_ready: got %b want 0", ready_b); else n_pass++;
        step();
        clear_b = 1'b0;
        #1;
        n_checks++; if (len_b !== 3'd0 || full_b !== 1'b0 || ready_b !== 1'b1)
            $display("FAIL full_after_clear: got len %0d full %b ready %b want 0 0 1", len_b, full_b, ready_b); else n_pass++;
        step();
        valid_b = 1'b0;
        n_checks++; if (wr_en_b !== 1'b1 || addr_b !== 2'd0 || data_b !== 32'h246811ED)
            $display("FAIL full_ss_word0: got en %b addr %0d data %h want 1 0 246811ed", wr_en_b, addr_b, data_b); else n_pass++;
        step();
        n_checks++; if (wr_en_b !== 1'b1 || addr_b !== 2'd1 || data_b !== 32'h11112222 || len_b !== 3'd2)
            $display("FAIL full_ss_word1: got en %b addr %0d data %h len %0d want 1 1 11112222 2",
                     wr_en_b, addr_b, data_b, len_b); else n_pass++;
    endtask

    task automatic test_err_and_clear();
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        cmd_a = mk(opUnsupported, 16'hFFFF, 16'hFFFF, 5'd31, 5'd31, 6'd63, 19'h7FFFF, 5'd31);
        valid_a = 1'b1;
        #1;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL err_ready: got %b want 1", ready_a); else n_pass++;
        step();
        valid_a = 1'b0;
        n_checks++; if (wr_en_a !== 1'b0 || err_a !== 1'b1 || len_a !== 11'd0)
            $display("FAIL err_unsup: got en %b err %b len %0d want 0 1 0", wr_en_a, err_a, len_a); else n_pass++;
        step();
        n_checks++; if (err_a !== 1'b0) $display("FAIL err_pulse: got %b want 0", err_a); else n_pass++;
        cmd_a = mk(opShapeData, 16'h1234, 16'h5678, 5'd0, 5'd0, 6'd0, 19'd0, 5'd0);
        valid_a = 1'b1;
        #1;
        step();
        valid_a = 1'b0;
        n_checks++; if (wr_en_a !== 1'b0 || err_a !== 1'b1 || len_a !== 11'd0)
            $display("FAIL err_sdata: got en %b err %b len %0d want 0 1 0", wr_en_a, err_a, len_a); else n_pass++;
        // clear while the second word is pending
        cmd_a = mk(opShapeSet, 16'hAAAA, 16'hBBBB, 5'd1, 5'd1, 6'd0, 19'd8, 5'd0);
        valid_a = 1'b1;
        #1;
        step();
        valid_a = 1'b0;
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        n_checks++; if (wr_en_a !== 1'b0 || len_a !== 11'd0)
            $display("FAIL clr_second: got en %b len %0d want 0 0", wr_en_a, len_a); else n_pass++;
        cmd_a = mk(opCameraSet, 16'h0001, 16'h0, 5'd0, 5'd0, 6'd0, 19'd0, 5'd0);
        valid_a = 1'b1;
        #1;
        step();
        valid_a = 1'b0;
        n_checks++; if (wr_en_a !== 1'b1 || addr_a !== 10'd0 || data_a !== 32'h00010002)
            $display("FAIL clr_next_addr: got en %b addr %0d data %h want 1 0 00010002", wr_en_a, addr_a, data_a); else n_pass++;
        // reset while the second word is pending
        cmd_a = mk(opShapeSet, 16'hAAAA, 16'hBBBB, 5'd1, 5'd1, 6'd0, 19'd8, 5'd0);
        valid_a = 1'b1;
        #1;
        step();
        valid_a = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (wr_en_a !== 1'b0 || addr_a !== 10'd0 || data_a !== 32'h0 || len_a !== 11'd0)
            $display("FAIL rst_second: got en %b addr %0d data %h len %0d want 0 0 0 0",
                     wr_en_a, addr_a, data_a, len_a); else n_pass++;
    endtask

    task automatic send_a(input DecodedInst c);
        int k;
        k = 0;
        cmd_a = c;
        valid_a = 1'b1;
        #1;
        while (!ready_a && k < 50) begin
            step();
            k++;
        end
        n_checks++;
        if (!ready_a) $display("FAIL send_timeout: got ready %b want 1 within 50 cycles", ready_a);
        else n_pass++;
        step();
        valid_a = 1'b0;
    endtask

    task automatic test_round_trip();
        DecodedInst q[$];
        DecodedInst c, e, g;
        int words;
        int p;
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        step();
        n_wr = 0;
        words = 0;
        for (int i = 0; i < 24; i++) begin
            c = mk(IType'($urandom_range(0, 5)), 16'($urandom), 16'($urandom), 5'($urandom),
                   5'($urandom), 6'($urandom), 19'($urandom), 5'($urandom));
            q.push_back(c);
            words += (c.iType == opShapeSet) ? 2 : 1;
            send_a(c);
        end
        repeat (3) step();
        n_checks++; if (n_wr !== words) $display("FAIL rt_words: got %0d want %0d", n_wr, words); else n_pass++;
        p = 0;
        foreach (q[i]) begin
            e = proj(q[i]);
            g = dec(mem[p], 1'b0);
            p++;
            n_checks++; if (g !== e) $display("FAIL rt_cmd%0d: got %h want %h", i, g, e); else n_pass++;
            if (q[i].iType == opShapeSet) begin
                e = '0;
                e.iType = opShapeData; e.data = q[i].data; e.data2 = q[i].data2;
                g = dec(mem[p], 1'b1);
                p++;
                n_checks++; if (g !== e) $display("FAIL rt_sdata%0d: got %h want %h", i, g, e); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_camera();
        test_back_to_back();
        test_shapeset();
        test_full();
        test_err_and_clear();
        test_round_trip();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
